// File: rtl/control_unit.sv
// control_unit: Moore FSM sequencing an 8-bit accumulator datapath.
// Fetch F0-F2, decode D3, execute S4-S8, HALT on unknown opcodes.
// Optional: CONTROL_UNIT_COND_BRANCH_EN enables BMI/BEQ/BCS; without it
// those opcodes halt like any other unknown opcode.
module control_unit (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic       CCR_Load,
  output logic [2:0] ALU_Sel,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic       write,
  output logic       halted
);

  localparam logic [7:0] OP_LDA_IMM = 8'h86, OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDA_DIR = 8'h87, OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96, OP_STB_DIR = 8'h97;
  localparam logic [7:0] OP_ADD = 8'h42, OP_DECA = 8'h47;
  localparam logic [7:0] OP_BRA = 8'h20, OP_BMI = 8'h21;
  localparam logic [7:0] OP_BEQ = 8'h23, OP_BCS = 8'h25;

  // S4N is the single PC_Inc step of a conditional branch that is not taken.
  typedef enum logic [3:0] {F0, F1, F2, D3, S4, S4N, S5, S6, S7, S8, HALT} state_t;

  state_t st, nxt;

  logic       is_imm, is_dir, is_st, is_alu, is_bra, is_cond, is_br, to_a;
  logic [7:0] alu_off;

  assign is_imm  = (IR == OP_LDA_IMM) || (IR == OP_LDB_IMM);
  assign is_dir  = (IR == OP_LDA_DIR) || (IR == OP_LDB_DIR);
  assign is_st   = (IR == OP_STA_DIR) || (IR == OP_STB_DIR);
  assign is_alu  = (IR >= OP_ADD) && (IR <= OP_DECA);
  assign is_bra  = (IR == OP_BRA);
  assign is_cond = (IR == OP_BMI) || (IR == OP_BEQ) || (IR == OP_BCS);
  assign is_br   = is_bra || is_cond;
  // LDA_* targets A, LDB_* targets B.
  assign to_a    = (IR == OP_LDA_IMM) || (IR == OP_LDA_DIR);
  // ALU opcodes 42..47 map straight onto ALU_Sel 0..5.
  assign alu_off = IR - OP_ADD;

`ifdef CONTROL_UNIT_COND_BRANCH_EN
  logic cond_taken;
  // Flag sampled during D3 to choose taken vs. not-taken path.
  always_comb begin
    cond_taken = 1'b0;
    case (IR)
      OP_BMI:  cond_taken = CCR_Result[3];
      OP_BEQ:  cond_taken = CCR_Result[2];
      OP_BCS:  cond_taken = CCR_Result[0];
      default: cond_taken = 1'b0;
    endcase
  end
`else
  logic unused_ccr;
  assign unused_ccr = ^CCR_Result;
`endif

  // State register; reset parks the machine in F0.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) st <= F0;
    else        st <= nxt;
  end

  // Next state and Moore outputs; everything forced idle while Reset is low.
  always_comb begin
    nxt      = F0;
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    A_Load   = 1'b0;
    B_Load   = 1'b0;
    CCR_Load = 1'b0;
    ALU_Sel  = 3'b000;
    Bus1_Sel = 2'b00;
    Bus2_Sel = 2'b00;
    write    = 1'b0;
    halted   = 1'b0;
    case (st)
      F0:  nxt = F1;
      F1:  nxt = F2;
      F2:  nxt = D3;
      D3: begin
        if (is_imm || is_dir || is_st || is_alu || is_bra) nxt = S4;
`ifdef CONTROL_UNIT_COND_BRANCH_EN
        else if (is_cond) nxt = cond_taken ? S4 : S4N;
`endif
        else nxt = HALT;
      end
      S4:   nxt = is_alu ? F0 : S5;
      S4N:  nxt = F0;
      S5:   nxt = S6;
      S6:   nxt = (is_dir || is_st) ? S7 : F0;
      S7:   nxt = is_dir ? S8 : F0;
      S8:   nxt = F0;
      HALT: nxt = HALT;
      default: nxt = F0;
    endcase

    if (Reset) begin
      case (st)
        F0: begin MAR_Load = 1'b1; Bus2_Sel = 2'b01; end
        F1: PC_Inc = 1'b1;
        F2: begin IR_Load = 1'b1; Bus2_Sel = 2'b10; end
        S4: begin
          if (is_alu) begin
            ALU_Sel  = alu_off[2:0];
            A_Load   = 1'b1;
            CCR_Load = 1'b1;
          end else begin
            MAR_Load = 1'b1;
            Bus2_Sel = 2'b01;
          end
        end
        S4N: PC_Inc = 1'b1;
        // Branches use the operand as the target, so the PC is not stepped.
        S5: PC_Inc = !is_br;
        S6: begin
          Bus2_Sel = 2'b10;
          if (is_imm) begin
            A_Load = to_a;
            B_Load = !to_a;
          end else if (is_dir || is_st) begin
            MAR_Load = 1'b1;
          end else begin
            PC_Load = 1'b1;
          end
        end
        S7: begin
          if (is_st) begin
            Bus1_Sel = (IR == OP_STA_DIR) ? 2'b01 : 2'b10;
            write    = 1'b1;
          end
        end
        S8: begin
          Bus2_Sel = 2'b10;
          A_Load   = to_a;
          B_Load   = !to_a;
        end
        HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes the per-cycle expected
// output vectors of each instruction; a negedge monitor pops and compares.
module tb_control_unit;

  typedef struct packed {
    logic       ir_ld, mar_ld, pc_ld, pc_inc, a_ld, b_ld, ccr_ld;
    logic [2:0] alu;
    logic [1:0] b1, b2;
    logic       wr, hlt;
  } ov_t;

  logic       Clk, Reset;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic       write, halted;

  control_unit dut (
    .Clk(Clk), .Reset(Reset), .IR(IR), .CCR_Result(CCR_Result),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load), .ALU_Sel(ALU_Sel),
    .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .write(write), .halted(halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  ov_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;

  function automatic ov_t got_vec();
    ov_t g;
    g = '{IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
          ALU_Sel, Bus1_Sel, Bus2_Sel, write, halted};
    return g;
  endfunction

  function automatic void check(input string name, input ov_t g, input ov_t e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d IR=%h got=%h exp=%h", name, cyc, IR, g, e);
    end
  endfunction

  // Monitor: every cycle the DUT presents outputs, compare against the queue.
  always @(negedge Clk) begin
    cyc++;
    if (exp_q.size() > 0) check("outputs", got_vec(), exp_q.pop_front());
  end

  // Reference model: expected cycle-by-cycle outputs of one instruction.
  function automatic void push(input ov_t s);
    exp_q.push_back(s);
  endfunction

  function automatic ov_t mar_from_pc();
    ov_t s = '0;
    s.mar_ld = 1'b1; s.b2 = 2'b01;
    return s;
  endfunction

  function automatic ov_t pc_step();
    ov_t s = '0;
    s.pc_inc = 1'b1;
    return s;
  endfunction

  function automatic ov_t mem_to(input bit a, input bit b, input bit mar, input bit pc);
    ov_t s = '0;
    s.b2 = 2'b10; s.a_ld = a; s.b_ld = b; s.mar_ld = mar; s.pc_ld = pc;
    return s;
  endfunction

  function automatic int model(input logic [7:0] op, input logic [3:0] ccr, output bit halts);
    int   n0 = exp_q.size();
    ov_t  s;
    bit   taken;
    halts = 1'b0;
    push(mar_from_pc());
    push(pc_step());
    s = '0; s.ir_ld = 1'b1; s.b2 = 2'b10; push(s);
    push('0);
    case (op)
      8'h86, 8'h88: begin
        push(mar_from_pc()); push(pc_step());
        push(mem_to(op == 8'h86, op == 8'h88, 1'b0, 1'b0));
      end
      8'h87, 8'h89: begin
        push(mar_from_pc()); push(pc_step());
        push(mem_to(1'b0, 1'b0, 1'b1, 1'b0));
        push('0);
        push(mem_to(op == 8'h87, op == 8'h89, 1'b0, 1'b0));
      end
      8'h96, 8'h97: begin
        push(mar_from_pc()); push(pc_step());
        push(mem_to(1'b0, 1'b0, 1'b1, 1'b0));
        s = '0; s.wr = 1'b1; s.b1 = (op == 8'h96) ? 2'b01 : 2'b10; push(s);
      end
      8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47: begin
        s = '0; s.alu = 3'(op - 8'h42); s.a_ld = 1'b1; s.ccr_ld = 1'b1; push(s);
      end
      8'h20: begin
        push(mar_from_pc()); push('0); push(mem_to(1'b0, 1'b0, 1'b0, 1'b1));
      end
`ifdef CONTROL_UNIT_COND_BRANCH_EN
      8'h21, 8'h23, 8'h25: begin
        taken = (op == 8'h21) ? ccr[3] : (op == 8'h23) ? ccr[2] : ccr[0];
        if (taken) begin
          push(mar_from_pc()); push('0); push(mem_to(1'b0, 1'b0, 1'b0, 1'b1));
        end else begin
          push(pc_step());
        end
      end
`endif
      default: begin
        halts = 1'b1;
        s = '0; s.hlt = 1'b1;
        repeat (20) push(s);
      end
    endcase
    return exp_q.size() - n0;
  endfunction

  function automatic bit known(input logic [7:0] op);
    case (op)
      8'h86, 8'h88, 8'h87, 8'h89, 8'h96, 8'h97, 8'h42, 8'h43, 8'h44, 8'h45,
      8'h46, 8'h47, 8'h20, 8'h21, 8'h23, 8'h25: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Called at posedge+1; leaves Reset released at posedge+1 with DUT in F0.
  task automatic do_reset();
    Reset = 1'b0;
    push('0); push('0);
    repeat (2) @(negedge Clk);
    @(posedge Clk); #1;
    Reset = 1'b1;
  endtask

  // Called at posedge+1 at the start of an F0 cycle.
  task automatic run_instr(input logic [7:0] op, input logic [3:0] ccr);
    int n;
    bit h;
    IR = op; CCR_Result = ccr;
    n = model(op, ccr, h);
    repeat (n) @(posedge Clk);
    #1;
    if (h) do_reset();
  endtask

  // Store interrupted by reset during its write cycle.
  task automatic sta_reset_mid_s7();
    int  n;
    bit  h;
    IR = 8'h96; CCR_Result = 4'h0;
    n = model(8'h96, 4'h0, h);
    repeat (n - 1) @(posedge Clk);
    @(negedge Clk); #1;
    Reset = 1'b0;
    #1 check("rst_mid_s7", got_vec(), '0);
    push('0);
    @(posedge Clk);
    @(posedge Clk); #1;
    Reset = 1'b1;
  endtask

  logic [7:0] ops[16] = '{8'h86, 8'h88, 8'h87, 8'h89, 8'h96, 8'h97, 8'h42, 8'h43,
                          8'h44, 8'h45, 8'h46, 8'h47, 8'h20, 8'h21, 8'h23, 8'h25};

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] op;
    Reset = 1'b0; IR = 8'h00; CCR_Result = 4'h0;
    push('0); push('0);
    repeat (2) @(negedge Clk);
    @(posedge Clk); #1;
    Reset = 1'b1;

    run_instr(8'h86, 4'h0);
    run_instr(8'h96, 4'h0);
    run_instr(8'h42, 4'h0);
    run_instr(8'h23, 4'b0100);
    run_instr(8'h23, 4'b0000);
    run_instr(8'h97, 4'hF);
    run_instr(8'h89, 4'h0);
    sta_reset_mid_s7();
    run_instr(8'h47, 4'h0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = 8'($urandom_range(0, 255));
        while (known(op)) op = 8'($urandom_range(0, 255));
      end else begin
        op = ops[$urandom_range(0, 15)];
      end
      run_instr(op, 4'($urandom_range(0, 15)));
    end

    run_instr(8'hFF, 4'h0);
    run_instr(8'h88, 4'h0);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
